// File: rtl/sata_prims_pkg.sv
// sata_prims_pkg: shared SATA primitive constants, link alignment states and helpers.
package sata_prims_pkg;
  localparam logic [31:0] ALIGN_DWORD   = 32'h7B4A4ABC;
  localparam logic [3:0]  ALIGN_CHARISK = 4'b0001;
  localparam logic [7:0]  K28_5         = 8'hBC;
  localparam logic [1:0]  UNLOCKED      = 2'd0;
  localparam logic [1:0]  LOCKING       = 2'd1;
  localparam logic [1:0]  LOCKED        = 2'd2;
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/sata_rx_dword_align_if.sv
// sata_rx_dword_align_if: PHY-side rx bus in, aligned link-side bus out.
// SATA_RX_ALIGN_STATS_EN adds the relock and error-byte counters.
interface sata_rx_dword_align_if;
  logic        phy_ready;
  logic [31:0] rxdata_in;
  logic [3:0]  rxcharisk_in;
  logic [3:0]  rxerr_in;
  logic [31:0] data_out;
  logic [3:0]  charisk_out;
  logic [3:0]  err_out;
  logic        aligned;
  logic        align_det;
  logic [1:0]  offset_out;
`ifdef SATA_RX_ALIGN_STATS_EN
  logic [15:0] relock_cnt;
  logic [15:0] err_byte_cnt;
`endif
  modport master (
`ifdef SATA_RX_ALIGN_STATS_EN
    input relock_cnt, err_byte_cnt,
`endif
    output phy_ready, rxdata_in, rxcharisk_in, rxerr_in,
    input data_out, charisk_out, err_out, aligned, align_det, offset_out
  );
  modport slave (
`ifdef SATA_RX_ALIGN_STATS_EN
    output relock_cnt, err_byte_cnt,
`endif
    input phy_ready, rxdata_in, rxcharisk_in, rxerr_in,
    output data_out, charisk_out, err_out, aligned, align_det, offset_out
  );
endinterface

// File: rtl/sata_byte_shifter.sv
// sata_byte_shifter: combinational 64-to-32 byte barrel shift of data/k/err windows.
module sata_byte_shifter (
  input  logic [63:0] data_win,
  input  logic [7:0]  k_win,
  input  logic [7:0]  err_win,
  input  logic [1:0]  offset,
  output logic [31:0] data,
  output logic [3:0]  k,
  output logic [3:0]  err
);
  assign data = data_win[{offset, 3'b000} +: 32];
  assign k    = k_win[offset +: 4];
  assign err  = err_win[offset +: 4];
endmodule

// File: rtl/sata_rx_dword_align.sv
// sata_rx_dword_align: locks onto the ALIGN K28.5 lane and shifts rx words so primitives start in lane 0.
// Optional SATA_RX_ALIGN_STATS_EN adds relock_cnt and err_byte_cnt.
module sata_rx_dword_align
  import sata_prims_pkg::*;
#(
  parameter int DATA_BYTE_WIDTH = 4,
  parameter int LOCK_COUNT      = 2,
  parameter int UNLOCK_ERRS     = 4
) (
  input logic clk,
  input logic rst,
  sata_rx_dword_align_if.slave bus
);
  localparam int DW = 8 * DATA_BYTE_WIDTH;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic [3:0] UE = 4'(UNLOCK_ERRS);
  logic [DW-1:0] prev_data;
  logic [3:0] prev_k, prev_err, hit, cnt, cnt_n, sh_k, sh_err;
  logic [1:0] state, state_n, offset, offset_n, cand, cand_n, hit_idx;
  logic [31:0] sh_data;
  logic [63:0] win_data;
  logic [7:0] win_k, win_err;
  assign win_data = {bus.rxdata_in, prev_data};
  assign win_k    = {bus.rxcharisk_in, prev_k};
  assign win_err  = {bus.rxerr_in, prev_err};
  for (genvar i = 0; i < 4; i++) begin : g_hit
    assign hit[i] = win_data[8*i +: 32] == ALIGN_DWORD && win_k[i +: 4] == ALIGN_CHARISK;
  end
  assign hit_idx = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
  sata_byte_shifter u_shift (
    .data_win(win_data), .k_win(win_k), .err_win(win_err), .offset(offset),
    .data(sh_data), .k(sh_k), .err(sh_err)
  );
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cand_n   = cand;
    offset_n = offset;
    if (!bus.phy_ready) begin
      state_n = UNLOCKED;
      cnt_n   = '0;
    end else if (|hit) begin
      case (state)
        UNLOCKED: begin
          state_n  = LC == 4'd1 ? LOCKED : LOCKING;
          offset_n = LC == 4'd1 ? hit_idx : offset;
          cand_n   = hit_idx;
          cnt_n    = LC == 4'd1 ? 4'd0 : 4'd1;
        end
        LOCKING: begin
          cand_n = hit_idx;
          cnt_n  = hit_idx == cand ? cnt + 4'd1 : 4'd1;
          if (hit_idx == cand && cnt_n == LC) begin
            state_n  = LOCKED;
            offset_n = cand;
            cnt_n    = '0;
          end
        end
        LOCKED: begin
          // cnt now counts consecutive ALIGNs seen at a foreign offset
          cnt_n = hit_idx == offset ? 4'd0 : cnt + 4'd1;
          if (cnt_n == UE) begin
            state_n = UNLOCKED;
            cnt_n   = '0;
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_data       <= '0;
      prev_k          <= '0;
      prev_err        <= '0;
      state           <= UNLOCKED;
      cnt             <= '0;
      cand            <= '0;
      offset          <= '0;
      bus.data_out    <= '0;
      bus.charisk_out <= '0;
      bus.err_out     <= '0;
      bus.align_det   <= 1'b0;
    end else begin
      prev_data       <= bus.rxdata_in;
      prev_k          <= bus.rxcharisk_in;
      prev_err        <= bus.rxerr_in;
      state           <= state_n;
      cnt             <= cnt_n;
      cand            <= cand_n;
      offset          <= offset_n;
      bus.data_out    <= sh_data;
      bus.charisk_out <= sh_k;
      bus.err_out     <= sh_err;
      bus.align_det   <= hit[offset];
    end
  end
  assign bus.aligned    = state == LOCKED;
  assign bus.offset_out = offset;
`ifdef SATA_RX_ALIGN_STATS_EN
  logic [16:0] err_sum;
  assign err_sum = 17'(bus.err_byte_cnt) + 17'(popcount4(bus.err_out));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.relock_cnt   <= '0;
      bus.err_byte_cnt <= '0;
    end else begin
      if (state == LOCKED && state_n == UNLOCKED && bus.relock_cnt != 16'hFFFF)
        bus.relock_cnt <= bus.relock_cnt + 16'd1;
      bus.err_byte_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_sata_rx_dword_align.sv
// tb_sata_rx_dword_align: directed checks of lock, tolerance, relock, phy_ready drop, error lanes and async reset.
module tb_sata_rx_dword_align;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vecs = 0;
  int errs = 0;
  sata_rx_dword_align_if bus ();
  sata_rx_dword_align dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e);
    bus.rxdata_in = d;
    bus.rxcharisk_in = k;
    bus.rxerr_in = e;
    @(posedge clk);
    #1;
  endtask

  // ALIGN whose K28.5 sits in lane l: spans this word and the next
  task automatic send_align(input int l, input logic pr = 1'b1);
    logic [31:0] a;
    a = 32'h7B4A4ABC;
    bus.phy_ready = 1'b1;
    push(a << (8 * l), 4'b0001 << l, 4'b0000);
    bus.phy_ready = pr;
    push(l == 0 ? 32'h0 : a >> (8 * (4 - l)), 4'b0000, 4'b0000);
    bus.phy_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.phy_ready = 1'b1;
    bus.rxdata_in = '0;
    bus.rxcharisk_in = '0;
    bus.rxerr_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.phy_ready = 1'b1;
    bus.rxdata_in = 32'hFFFFFFFF;
    bus.rxcharisk_in = 4'hF;
    bus.rxerr_in = 4'hF;
    #1;
    vecs++; if (bus.data_out !== 32'h0) begin errs++; $display("FAIL reset_data got %h exp 00000000", bus.data_out); end
    vecs++; if ({bus.charisk_out, bus.err_out} !== 8'h00) begin errs++; $display("FAIL reset_k_err got %h exp 00", {bus.charisk_out, bus.err_out}); end
    vecs++; if ({bus.aligned, bus.align_det, bus.offset_out} !== 4'b0000) begin errs++; $display("FAIL reset_status got %b exp 0000", {bus.aligned, bus.align_det, bus.offset_out}); end
`ifdef SATA_RX_ALIGN_STATS_EN
    vecs++; if ({bus.relock_cnt, bus.err_byte_cnt} !== 32'h0) begin errs++; $display("FAIL reset_stats got %h exp 0", {bus.relock_cnt, bus.err_byte_cnt}); end
`endif
    do_reset();
  endtask

  task automatic test_lock_lane2();
    do_reset();
    send_align(2);
    vecs++; if (bus.aligned !== 1'b0) begin errs++; $display("FAIL lock2_first got %b exp 0", bus.aligned); end
    send_align(2);
    vecs++; if (bus.aligned !== 1'b1) begin errs++; $display("FAIL lock2_second got %b exp 1", bus.aligned); end
    vecs++; if (bus.offset_out !== 2'd2) begin errs++; $display("FAIL lock2_offset got %0d exp 2", bus.offset_out); end
    send_align(2);
    vecs++; if (bus.data_out !== 32'h7B4A4ABC) begin errs++; $display("FAIL lock2_data got %h exp 7b4a4abc", bus.data_out); end
    vecs++; if (bus.charisk_out !== 4'b0001) begin errs++; $display("FAIL lock2_k got %b exp 0001", bus.charisk_out); end
    vecs++; if (bus.align_det !== 1'b1) begin errs++; $display("FAIL lock2_det got %b exp 1", bus.align_det); end
  endtask

  task automatic test_tolerance();
    do_reset();
    send_align(0);
    send_align(0);
    vecs++; if ({bus.aligned, bus.offset_out} !== 3'b100) begin errs++; $display("FAIL tol_lock0 got %b exp 100", {bus.aligned, bus.offset_out}); end
    for (int i = 0; i < 3; i++) send_align(1);
    vecs++; if (bus.aligned !== 1'b1) begin errs++; $display("FAIL tol_three_miss got %b exp 1", bus.aligned); end
    send_align(0);
    for (int i = 0; i < 3; i++) send_align(1);
    vecs++; if (bus.aligned !== 1'b1) begin errs++; $display("FAIL tol_cnt_cleared got %b exp 1", bus.aligned); end
    send_align(1);
    vecs++; if ({bus.aligned, bus.offset_out} !== 3'b000) begin errs++; $display("FAIL tol_fourth_drop got %b exp 000", {bus.aligned, bus.offset_out}); end
  endtask

  task automatic test_relock();
    do_reset();
    send_align(0);
    send_align(0);
    for (int i = 0; i < 3; i++) send_align(3);
    vecs++; if (bus.aligned !== 1'b1) begin errs++; $display("FAIL relock_hold got %b exp 1", bus.aligned); end
    send_align(3);
    vecs++; if ({bus.aligned, bus.offset_out} !== 3'b000) begin errs++; $display("FAIL relock_drop got %b exp 000", {bus.aligned, bus.offset_out}); end
`ifdef SATA_RX_ALIGN_STATS_EN
    vecs++; if (bus.relock_cnt !== 16'd1) begin errs++; $display("FAIL relock_stat got %0d exp 1", bus.relock_cnt); end
`endif
    send_align(3);
    vecs++; if (bus.aligned !== 1'b0) begin errs++; $display("FAIL relock_locking got %b exp 0", bus.aligned); end
    send_align(3);
    vecs++; if ({bus.aligned, bus.offset_out} !== 3'b111) begin errs++; $display("FAIL relock_lane3 got %b exp 111", {bus.aligned, bus.offset_out}); end
    send_align(3);
    vecs++; if ({bus.data_out, bus.charisk_out, bus.align_det} !== {32'h7B4A4ABC, 4'b0001, 1'b1}) begin errs++; $display("FAIL relock_data got %h exp 7b4a4abc13", {bus.data_out, bus.charisk_out, bus.align_det}); end
  endtask

  task automatic test_phy_ready();
    bus.phy_ready = 1'b0;
    push(32'h0, 4'b0000, 4'b0000);
    vecs++; if ({bus.aligned, bus.offset_out} !== 3'b011) begin errs++; $display("FAIL phy_drop got %b exp 011", {bus.aligned, bus.offset_out}); end
    bus.phy_ready = 1'b1;
    send_align(3);
    vecs++; if (bus.aligned !== 1'b0) begin errs++; $display("FAIL phy_fresh1 got %b exp 0", bus.aligned); end
    send_align(3);
    vecs++; if (bus.aligned !== 1'b1) begin errs++; $display("FAIL phy_fresh2 got %b exp 1", bus.aligned); end
    bus.phy_ready = 1'b0;
    push(32'h0, 4'b0000, 4'b0000);
    send_align(3, 1'b0);
    send_align(3);
    vecs++; if (bus.aligned !== 1'b0) begin errs++; $display("FAIL phy_wins got %b exp 0", bus.aligned); end
    send_align(3);
    vecs++; if (bus.aligned !== 1'b1) begin errs++; $display("FAIL phy_wins_relock got %b exp 1", bus.aligned); end
  endtask

  task automatic test_err_lane();
    do_reset();
    send_align(2);
    send_align(2);
    push(32'h00AA0000, 4'b0000, 4'b0100);
    push(32'h0, 4'b0000, 4'b0000);
    vecs++; if (bus.err_out !== 4'b0001) begin errs++; $display("FAIL err_shift got %b exp 0001", bus.err_out); end
    vecs++; if (bus.data_out !== 32'h000000AA) begin errs++; $display("FAIL err_data got %h exp 000000aa", bus.data_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_align(1);
    vecs++; if ({bus.data_out, bus.charisk_out} !== {32'h4A4ABC00, 4'b0010}) begin errs++; $display("FAIL pre_rst_word got %h exp 4a4abc002", {bus.data_out, bus.charisk_out}); end
    #2 rst = 1'b0;
    #1;
    vecs++; if ({bus.data_out, bus.charisk_out, bus.err_out, bus.aligned, bus.align_det, bus.offset_out} !== 44'h0) begin errs++; $display("FAIL async_rst got %h exp 0", {bus.data_out, bus.charisk_out, bus.err_out, bus.aligned, bus.align_det, bus.offset_out}); end
`ifdef SATA_RX_ALIGN_STATS_EN
    vecs++; if ({bus.relock_cnt, bus.err_byte_cnt} !== 32'h0) begin errs++; $display("FAIL async_rst_stats got %h exp 0", {bus.relock_cnt, bus.err_byte_cnt}); end
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    send_align(1);
    vecs++; if (bus.aligned !== 1'b0) begin errs++; $display("FAIL post_rst_unlocked got %b exp 0", bus.aligned); end
    send_align(1);
    vecs++; if ({bus.aligned, bus.offset_out} !== 3'b101) begin errs++; $display("FAIL post_rst_lock got %b exp 101", {bus.aligned, bus.offset_out}); end
  endtask

  initial begin
    test_reset();
    test_lock_lane2();
    test_tolerance();
    test_relock();
    test_phy_ready();
    test_err_lane();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
